clk_ratio_meter: RTL and testbench
==================================

Name: clk_ratio_meter

Overview:
- Measures an incoming divided clock against the reference clock: period and high time in ref_clk cycles, checked against an expected ratio, with lock and timeout status.
- It is the receive-side checker for the clock divider: it takes the divider output (o_div_clk) on i_div_clk and the divider's programmed div_ratio on i_exp_ratio.
- Used for on-chip self-check and as a reusable monitor in the divider bench.

Parameters:
- WIDTH, 8, width of the ratio and count fields; the maximum measurable period is 2^WIDTH-1.
- SYNC_STAGES, 2, number of flops on i_div_clk before edge detection (legal range 1..3).
- LOCK_COUNT, 3, number of consecutive identical measurements after the first that are required for lock.

Ports:
- ref_clk  in  1  reference clock; all logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  measurement enable.
- i_div_clk  in  1  divided clock under measurement.
- i_exp_ratio  in  WIDTH  expected period in ref_clk cycles.
- o_period  out  WIDTH  last measured period.
- o_high  out  WIDTH  last measured high time.
- o_valid  out  1  one-cycle pulse when o_period/o_high update.
- o_err  out  1  one-cycle pulse, coincident with o_valid, when o_period != i_exp_ratio.
- o_locked  out  1  measurement is stable.
- o_timeout  out  1  sticky flag: no rising edge was seen within the counter range.

Behaviour:
- Reset: all outputs 0, state IDLE, all internal counters 0. Reset wins over every other event in the same cycle.
- Input conditioning and edges:
  - s = i_div_clk delayed by SYNC_STAGES flops; p = s delayed by 1.
  - rise = s & ~p; fall = ~s & p.
  - Edge latency from i_div_clk to rise is SYNC_STAGES+1 cycles. Measurements are relative, so this latency does not affect results.
- States:
  - IDLE: counters held at 0. i_en=1 -> WAIT_EDGE.
  - WAIT_EDGE: on rise -> MEASURE, with pcnt=1 and hcnt=1.
  - MEASURE: per cycle, see below.
  - From any state, i_en=0 -> IDLE next cycle. On that transition: o_locked=0, o_timeout=0, match counter=0; o_period/o_high hold their values.
- MEASURE, cycle by cycle:
  - No rise: pcnt++ (saturating at 2^WIDTH-1). hcnt++ if s=1; hcnt holds after fall.
  - Rise: o_period<=pcnt, o_high<=hcnt, o_valid=1 for one cycle, then pcnt=1, hcnt=1.
  - Result: a rise-to-rise spacing of N cycles reports exactly N; H high cycles report exactly H.
- Error: o_err=1 in the o_valid cycle iff pcnt != i_exp_ratio. i_exp_ratio is sampled in that cycle.
- Lock:
  - The first valid after entering MEASURE sets mcnt=0 and stores the reference pair (period, high).
  - Each later valid whose pair equals the previous pair: mcnt++, saturating at LOCK_COUNT.
  - Any mismatching valid: mcnt=0, o_locked=0.
  - o_locked=1 from the valid cycle in which mcnt reaches LOCK_COUNT.
- Timeout:
  - In MEASURE with pcnt == 2^WIDTH-1 and no rise: o_timeout<=1, o_locked<=0, mcnt=0, -> WAIT_EDGE, and no o_valid.
  - A rise in the same cycle that pcnt == max is a normal capture of max, with no timeout.
  - o_timeout clears only on rst or i_en=0.
- Constant-high input: hcnt also saturates at 2^WIDTH-1; the timeout path then applies.
- Minimum period is 2 (alternating sample values). A period of 1 is not representable after sampling and needs no special handling.

Test Plan:
- Divider at ratio 10 (high 5, low 5), i_exp_ratio=10, i_en=1 after reset:
  - o_valid every 10 cycles, with o_period=10, o_high=5, o_err=0.
  - o_locked=1 on the 4th valid (first valid plus 3 matches).
- Bench waveform high 3 / low 4, i_exp_ratio=7:
  - o_period=7, o_high=3, locked after 4 valids.
  - Change i_exp_ratio to 8 -> o_err pulses with every o_valid; o_locked stays 1.
- Locked at ratio 10, switch to ratio 6:
  - First valid after the switch reports a transitional period (between 6 and 10).
  - o_locked drops on the first mismatching valid.
  - Relocks with o_period=6 after 3 further matching valids.
- WIDTH=8, i_div_clk held low after lock:
  - o_timeout=1 when pcnt reaches 255, o_locked=0, no o_valid.
  - Restarting toggling resumes measurement while o_timeout stays 1.
  - o_timeout clears only after i_en pulses low.
- Mid-measurement events:
  - rst asserted -> all outputs 0 on the next cycle.
  - i_en dropped -> IDLE, o_locked=0, o_period holds 10.
  - i_en re-raised -> the first valid comes after two rises.
- Boundary: period exactly 255 reports o_period=255 with no timeout; period 256 sets o_timeout with no valid.

Source files
------------

// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of a divided clock in ref_clk cycles,
// compares the period against an expected ratio, and reports lock/timeout status.
module clk_ratio_meter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 3
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_div_clk,
  input  logic [WIDTH-1:0] i_exp_ratio,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int unsigned       MCNT_W   = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [MCNT_W-1:0] MCNT_SAT = MCNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                s;
  logic                p;
  logic                rise;
  logic [WIDTH-1:0]    pcnt;
  logic [WIDTH-1:0]    hcnt;
  logic [MCNT_W-1:0]   mcnt;
  logic                have_ref;
  logic                start_c;
  logic                capture_c;
  logic                timeout_c;
  logic [MCNT_W-1:0]   mcnt_next_c;

  // Synchronizer chain plus one extra flop for edge detection
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      sync_q <= '0;
      p      <= 1'b0;
    end else begin
      sync_q[0] <= i_div_clk;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      p <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!i_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      state_next = WAIT_EDGE;
        WAIT_EDGE: if (rise) state_next = MEASURE;
        MEASURE:   if (timeout_c) state_next = WAIT_EDGE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Per-cycle control strobes and the lock-counter update
  always_comb begin
    start_c     = 1'b0;
    capture_c   = 1'b0;
    timeout_c   = 1'b0;
    mcnt_next_c = '0;
    if (i_en) begin
      case (state)
        WAIT_EDGE: start_c = rise;
        MEASURE: begin
          capture_c = rise;
          timeout_c = !rise && (pcnt == CNT_MAX);
        end
        default: ;
      endcase
    end
    // The previously reported pair doubles as the reference for matching
    if (have_ref && (o_period == pcnt) && (o_high == hcnt)) begin
      mcnt_next_c = (mcnt == MCNT_SAT) ? mcnt : mcnt + MCNT_W'(1);
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      pcnt      <= '0;
      hcnt      <= '0;
      mcnt      <= '0;
      have_ref  <= 1'b0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_locked  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= capture_c;
      o_err   <= capture_c && (pcnt != i_exp_ratio);
      if (!i_en) begin
        pcnt      <= '0;
        hcnt      <= '0;
        mcnt      <= '0;
        have_ref  <= 1'b0;
        o_locked  <= 1'b0;
        o_timeout <= 1'b0;
      end else if (state == IDLE) begin
        pcnt <= '0;
        hcnt <= '0;
      end else if (start_c) begin
        pcnt     <= CNT_ONE;
        hcnt     <= CNT_ONE;
        have_ref <= 1'b0;
      end else if (capture_c) begin
        o_period <= pcnt;
        o_high   <= hcnt;
        pcnt     <= CNT_ONE;
        hcnt     <= CNT_ONE;
        have_ref <= 1'b1;
        mcnt     <= mcnt_next_c;
        o_locked <= (mcnt_next_c == MCNT_SAT);
      end else if (timeout_c) begin
        o_timeout <= 1'b1;
        o_locked  <= 1'b0;
        mcnt      <= '0;
      end else if (state == MEASURE) begin
        if (pcnt != CNT_MAX) begin
          pcnt <= pcnt + CNT_ONE;
        end
        if (s && (hcnt != CNT_MAX)) begin
          hcnt <= hcnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: table of steady waveforms plus
// hand-written sequences for ratio switch, timeout, reset and enable corners.
module tb_clk_ratio_meter;

  localparam int unsigned WIDTH = 8;

  logic             ref_clk = 1'b0;
  logic             rst;
  logic             i_en;
  logic             i_div_clk;
  logic [WIDTH-1:0] i_exp_ratio;
  logic [WIDTH-1:0] o_period;
  logic [WIDTH-1:0] o_high;
  logic             o_valid;
  logic             o_err;
  logic             o_locked;
  logic             o_timeout;

  clk_ratio_meter #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2),
    .LOCK_COUNT (3)
  ) dut (
    .ref_clk    (ref_clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_div_clk  (i_div_clk),
    .i_exp_ratio(i_exp_ratio),
    .o_period   (o_period),
    .o_high     (o_high),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_locked   (o_locked),
    .o_timeout  (o_timeout)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    int high;
    int low;
    int exp_ratio;
    int period;
    int hi_time;
    int err;
  } vec_t;

  vec_t vecs [5];

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int rises      = 0;
  int phase      = 0;
  int wave_high  = 5;
  int wave_low   = 5;
  int last_vcyc  = 0;
  bit wave_on    = 1'b0;
  bit hold_level = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One ref_clk cycle: outputs are stable at the falling edge, then the next input level is driven
  task automatic tick();
    logic nxt;
    @(negedge ref_clk);
    cyc++;
    if (wave_on) begin
      nxt   = (phase < wave_high);
      phase = (phase + 1 >= wave_high + wave_low) ? 0 : phase + 1;
    end else begin
      nxt = hold_level;
    end
    if (nxt && !i_div_clk) rises++;
    i_div_clk = nxt;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic expect_valid(input string tag, input int per, input int hi, input int err,
                              input int lck, input bit chk_space);
    bit ok;
    int prev;
    prev = last_vcyc;
    wait_valid(600, ok);
    last_vcyc = cyc;
    check({tag, "_arrive"}, int'(ok), 1);
    check({tag, "_period"}, int'(o_period), per);
    check({tag, "_high"}, int'(o_high), hi);
    check({tag, "_err"}, int'(o_err), err);
    check({tag, "_locked"}, int'(o_locked), lck);
    if (chk_space) check({tag, "_spacing"}, last_vcyc - prev, per);
  endtask

  task automatic enable_wave(input int h, input int l, input int exp);
    i_en       = 1'b0;
    wave_on    = 1'b0;
    hold_level = 1'b0;
    repeat (4) tick();
    wave_high   = h;
    wave_low    = l;
    phase       = 0;
    i_exp_ratio = WIDTH'(exp);
    rises       = 0;
    wave_on     = 1'b1;
    i_en        = 1'b1;
  endtask

  task automatic lock10(input string tag);
    enable_wave(5, 5, 10);
    for (int k = 1; k <= 4; k++) begin
      expect_valid($sformatf("%s_v%0d", tag, k), 10, 5, 0, (k == 4) ? 1 : 0, k >= 2);
    end
  endtask

  initial begin
    bit ok;
    bit seen_valid;
    int n;
    vecs[0] = '{high: 5, low: 5, exp_ratio: 10, period: 10, hi_time: 5, err: 0};
    vecs[1] = '{high: 3, low: 4, exp_ratio: 7,  period: 7,  hi_time: 3, err: 0};
    vecs[2] = '{high: 1, low: 1, exp_ratio: 2,  period: 2,  hi_time: 1, err: 0};
    vecs[3] = '{high: 2, low: 3, exp_ratio: 4,  period: 5,  hi_time: 2, err: 1};
    vecs[4] = '{high: 7, low: 1, exp_ratio: 8,  period: 8,  hi_time: 7, err: 0};

    rst         = 1'b1;
    i_en        = 1'b0;
    i_div_clk   = 1'b0;
    i_exp_ratio = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_period", int'(o_period), 0);
    check("rst_high", int'(o_high), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_locked", int'(o_locked), 0);
    check("rst_timeout", int'(o_timeout), 0);

    // Steady waveforms: lock is expected on the 4th valid
    for (int v = 0; v < 5; v++) begin
      enable_wave(vecs[v].high, vecs[v].low, vecs[v].exp_ratio);
      for (int k = 1; k <= 5; k++) begin
        expect_valid($sformatf("vec%0d_v%0d", v, k), vecs[v].period, vecs[v].hi_time,
                     vecs[v].err, (k >= 4) ? 1 : 0, k >= 2);
      end
    end

    // Expected ratio change while locked: err pulses, lock holds
    enable_wave(3, 4, 7);
    for (int k = 1; k <= 4; k++) begin
      expect_valid($sformatf("exp7_v%0d", k), 7, 3, 0, (k == 4) ? 1 : 0, k >= 2);
    end
    i_exp_ratio = WIDTH'(8);
    for (int k = 1; k <= 2; k++) begin
      expect_valid($sformatf("exp8_v%0d", k), 7, 3, 1, 1, 1'b1);
    end

    // Ratio switch 10 -> 6 inserted at phase 7: transitional pair is (8,5)
    lock10("sw_lock");
    for (int i = 0; i < 20 && phase != 7; i++) tick();
    check("sw_phase_reached", phase, 7);
    wave_high   = 3;
    wave_low    = 3;
    i_exp_ratio = WIDTH'(6);
    expect_valid("sw_trans", 8, 5, 1, 0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      expect_valid($sformatf("sw_v%0d", k), 6, 3, 0, (k == 5) ? 1 : 0, k >= 3);
    end

    // Input stuck low after lock: timeout exactly 255 cycles after the last valid
    lock10("to_lock");
    wave_on    = 1'b0;
    hold_level = 1'b0;
    seen_valid = 1'b0;
    n          = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n++;
      if (o_valid) seen_valid = 1'b1;
      if (o_timeout) break;
    end
    check("to_cycles", n, 255);
    check("to_flag", int'(o_timeout), 1);
    check("to_no_valid", int'(seen_valid), 0);
    check("to_locked", int'(o_locked), 0);
    phase   = 0;
    wave_on = 1'b1;
    expect_valid("to_resume", 10, 5, 0, 0, 1'b0);
    check("to_sticky", int'(o_timeout), 1);
    i_en = 1'b0;
    tick();
    check("to_clear", int'(o_timeout), 0);
    check("to_clear_locked", int'(o_locked), 0);

    // Period exactly at the counter maximum is a normal measurement
    enable_wave(1, 254, 255);
    expect_valid("p255", 255, 1, 0, 0, 1'b0);
    check("p255_timeout", int'(o_timeout), 0);

    // One cycle longer than the maximum never produces a valid
    enable_wave(1, 255, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (o_valid) seen_valid = 1'b1;
    end
    check("p256_no_valid", int'(seen_valid), 0);
    check("p256_timeout", int'(o_timeout), 1);

    // Synchronous reset mid-measurement clears every output
    lock10("rst_lock");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_period", int'(o_period), 0);
    check("mrst_high", int'(o_high), 0);
    check("mrst_valid", int'(o_valid), 0);
    check("mrst_err", int'(o_err), 0);
    check("mrst_locked", int'(o_locked), 0);
    check("mrst_timeout", int'(o_timeout), 0);

    // Enable drop: lock clears, measurement holds; re-enable needs two rises
    lock10("en_lock");
    i_en = 1'b0;
    tick();
    check("endrop_locked", int'(o_locked), 0);
    check("endrop_period", int'(o_period), 10);
    check("endrop_valid", int'(o_valid), 0);
    wave_on    = 1'b0;
    hold_level = 1'b0;
    repeat (3) tick();
    phase   = 0;
    rises   = 0;
    wave_on = 1'b1;
    i_en    = 1'b1;
    wait_valid(300, ok);
    check("reen_arrive", int'(ok), 1);
    check("reen_rises", rises, 2);
    check("reen_period", int'(o_period), 10);
    check("reen_locked", int'(o_locked), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
